// File: rtl/pc_pkg.sv
// Shared types and derived constants for the IF-stage program-counter generator.
// Derived widths here reflect the default configuration and seed the module parameter defaults.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } pc_state_t;

  localparam int PC_DEF_INC       = 4;
  localparam int PC_DEF_RAS_DEPTH = 4;
  localparam int ALIGN_BITS       = $clog2(PC_DEF_INC);
  localparam int RAS_PTR_W        = $clog2(PC_DEF_RAS_DEPTH);

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry and the count saturates.
// Push wins over pop; a pop on an empty stack is ignored.
module pc_ras
  import pc_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 1 << RAS_PTR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [N-1:0] i_data,
  output logic [N-1:0] o_top,
  output logic         o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [N-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_topIdx;
  logic [PTR_W-1:0] w_pushIdx;
  logic [PTR_W:0]   r_count;
  logic             w_full;

  assign w_pushIdx = r_topIdx + 1'b1;
  assign w_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_top     = r_mem[r_topIdx];

  // The top index simply wraps, so overwriting the oldest entry needs no extra logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_topIdx <= '0;
      r_count  <= '0;
    end else if (i_push) begin
      r_topIdx <= w_pushIdx;
      if (!w_full) begin
        r_count <= r_count + 1'b1;
      end
    end else if (i_pop && !o_empty) begin
      r_topIdx <= r_topIdx - 1'b1;
      r_count  <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && i_push) begin
      r_mem[w_pushIdx] <= i_data;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// IF-stage program counter: reset vector, increment, stall, redirect, halt/resume, fetch-valid.
// Define PC_RAS_EN to add call/ret ports backed by a return-address stack (pc_ras).
module pc_gen
  import pc_pkg::*;
#(
  parameter int           N         = 32,
  parameter int           INC       = 1 << ALIGN_BITS,
  parameter logic [N-1:0] RESET_PC  = '0,
  parameter int           RAS_DEPTH = 1 << RAS_PTR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect,
  input  logic [N-1:0] target,
  input  logic         halt,
  input  logic         resume,
`ifdef PC_RAS_EN
  input  logic         call,
  input  logic         ret,
  output logic         ras_err,
`endif
  output logic [N-1:0] pc,
  output logic         pc_valid,
  output logic         misalign,
  output logic         halted
);

  localparam logic [N-1:0] INC_V      = N'(INC);
  localparam logic [N-1:0] ALIGN_MASK = N'(INC - 1);

  if (INC < 1 || (INC & (INC - 1)) != 0) begin : g_badInc
    $error("pc_gen: INC must be a power of two");
  end
  if ((RESET_PC & ALIGN_MASK) != '0) begin : g_badResetPc
    $error("pc_gen: RESET_PC must be INC-aligned");
  end
  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_badRasDepth
    $error("pc_gen: RAS_DEPTH must be a power of two >= 2");
  end

  pc_state_t    r_state;
  pc_state_t    w_stateNext;
  logic [N-1:0] r_pc;
  logic [N-1:0] w_pcNext;
  logic [N-1:0] w_pcInc;
  logic [N-1:0] w_targetAligned;
  logic         w_targetMis;
  logic         r_misalign;
  logic         w_misNext;

`ifdef PC_RAS_EN
  logic         w_push;
  logic         w_pop;
  logic         w_rasEmpty;
  logic [N-1:0] w_rasTop;
  logic         r_rasErr;
  logic         w_rasErrNext;

  pc_ras #(
    .N     (N),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pcInc),
    .o_top   (w_rasTop),
    .o_empty (w_rasEmpty)
  );
`endif

  assign w_pcInc         = r_pc + INC_V;
  assign w_targetAligned = target & ~ALIGN_MASK;
  assign w_targetMis     = |(target & ALIGN_MASK);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Redirect outranks halt and stall; stall only blocks increment and stack traffic.
  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    w_misNext   = 1'b0;
`ifdef PC_RAS_EN
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_rasErrNext = 1'b0;
`endif
    case (r_state)
      BOOT: begin
        w_stateNext = RUN;
      end
      RUN: begin
        if (redirect) begin
          w_pcNext  = w_targetAligned;
          w_misNext = w_targetMis;
`ifdef PC_RAS_EN
          w_push = call & ~stall;
`endif
        end else if (halt) begin
          w_stateNext = HALTED;
        end else if (!stall) begin
`ifdef PC_RAS_EN
          if (ret && !w_rasEmpty) begin
            w_pcNext = w_rasTop;
            w_pop    = 1'b1;
          end else begin
            w_pcNext     = w_pcInc;
            w_rasErrNext = ret;
          end
`else
          w_pcNext = w_pcInc;
`endif
        end
      end
      HALTED: begin
        if (redirect) begin
          w_pcNext    = w_targetAligned;
          w_misNext   = w_targetMis;
          w_stateNext = RUN;
        end else if (resume) begin
          w_pcNext    = w_pcInc;
          w_stateNext = RUN;
        end
      end
      default: begin
        w_stateNext = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
`ifdef PC_RAS_EN
      r_rasErr   <= 1'b0;
`endif
    end else begin
      r_pc       <= w_pcNext;
      r_misalign <= w_misNext;
`ifdef PC_RAS_EN
      r_rasErr   <= w_rasErrNext;
`endif
    end
  end

  always_comb begin
    pc       = r_pc;
    misalign = r_misalign;
    pc_valid = (r_state == RUN);
    halted   = (r_state == HALTED);
`ifdef PC_RAS_EN
    ras_err  = r_rasErr;
`endif
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (N=32, INC=4, RESET_PC=0x100, RAS_DEPTH=2).
// The return-address-stack section runs only when PC_RAS_EN is defined.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] target;
  logic        halt;
  logic        resume;
  logic [31:0] pc;
  logic        pc_valid;
  logic        misalign;
  logic        halted;
`ifdef PC_RAS_EN
  logic        call;
  logic        ret;
  logic        ras_err;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  pc_gen #(
    .N         (32),
    .INC       (4),
    .RESET_PC  (32'h0000_0100),
    .RAS_DEPTH (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .redirect (redirect),
    .target   (target),
    .halt     (halt),
    .resume   (resume),
`ifdef PC_RAS_EN
    .call     (call),
    .ret      (ret),
    .ras_err  (ras_err),
`endif
    .pc       (pc),
    .pc_valid (pc_valid),
    .misalign (misalign),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iStall, input logic iRedirect,
                               input logic [31:0] iTarget, input logic iHalt,
                               input logic iResume);
    stall    = iStall;
    redirect = iRedirect;
    target   = iTarget;
    halt     = iHalt;
    resume   = iResume;
    tick();
  endtask

  task automatic checkField(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] expPc,
                             input logic expValid, input logic expMis,
                             input logic expHalted);
    checkField({tag, ".pc"}, pc, expPc);
    checkField({tag, ".pc_valid"}, {31'b0, pc_valid}, {31'b0, expValid});
    checkField({tag, ".misalign"}, {31'b0, misalign}, {31'b0, expMis});
    checkField({tag, ".halted"}, {31'b0, halted}, {31'b0, expHalted});
  endtask

  initial begin
    reset    = 1'b1;
    stall    = 1'b0;
    redirect = 1'b0;
    target   = '0;
    halt     = 1'b0;
    resume   = 1'b0;
`ifdef PC_RAS_EN
    call     = 1'b0;
    ret      = 1'b0;
`endif

    // Reset, one BOOT cycle, then free run
    tick();
    tick();
    checkOutput("boot", 32'h100, 1'b0, 1'b0, 1'b0);
`ifdef PC_RAS_EN
    checkField("boot.ras_err", {31'b0, ras_err}, 32'h0);
`endif
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("run0", 32'h100, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("run1", 32'h104, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("run2", 32'h108, 1'b1, 1'b0, 1'b0);

    // Stall three cycles; misaligned redirect during the second one
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("stall1", 32'h108, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h2002, 1'b0, 1'b0);
    checkOutput("stallRedir", 32'h2000, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("stall3", 32'h2000, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("afterStall", 32'h2004, 1'b1, 1'b0, 1'b0);

    // Halt at 0x200 for five cycles, stall ignored, then resume
    applyStimulus(1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
    checkOutput("toHaltPc", 32'h200, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("halt0", 32'h200, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("haltHold", 32'h200, 1'b0, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("resume", 32'h204, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("postResume", 32'h208, 1'b1, 1'b0, 1'b0);

    // Redirect beats halt in the same cycle
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b1, 1'b0);
    checkOutput("redirOverHalt", 32'h300, 1'b1, 1'b0, 1'b0);

    // Top-of-space wrap
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    checkOutput("wrapTop", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("wrapZero", 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("wrapFour", 32'h4, 1'b1, 1'b0, 1'b0);

    // Misaligned redirect out of HALTED
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("halt2", 32'h4, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h403, 1'b0, 1'b0);
    checkOutput("haltRedir", 32'h400, 1'b1, 1'b1, 1'b0);

    // Reset while HALTED with a redirect pending
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("halt3", 32'h400, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h800, 1'b0, 1'b0);
    checkOutput("resetHalted", 32'h100, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h800, 1'b0, 1'b0);
    checkOutput("bootIgnores", 32'h100, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("postReset", 32'h104, 1'b1, 1'b0, 1'b0);

`ifdef PC_RAS_EN
    // Three calls into a two-entry stack, then three returns
    applyStimulus(1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
    checkOutput("rasStart", 32'h10, 1'b1, 1'b0, 1'b0);
    call = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h20, 1'b0, 1'b0);
    checkOutput("call1", 32'h20, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h30, 1'b0, 1'b0);
    checkOutput("call2", 32'h30, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
    checkOutput("call3", 32'h40, 1'b1, 1'b0, 1'b0);
    call = 1'b0;
    ret  = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("ret1", 32'h34, 1'b1, 1'b0, 1'b0);
    checkField("ret1.ras_err", {31'b0, ras_err}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("ret2", 32'h24, 1'b1, 1'b0, 1'b0);
    checkField("ret2.ras_err", {31'b0, ras_err}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("ret3", 32'h28, 1'b1, 1'b0, 1'b0);
    checkField("ret3.ras_err", {31'b0, ras_err}, 32'h1);
    ret = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("postRet", 32'h2C, 1'b1, 1'b0, 1'b0);
    checkField("postRet.ras_err", {31'b0, ras_err}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the IF stage. Next generation of the plain PC register.
- Adds reset vector, sequential increment, stall, branch/jump redirect, halt/resume, and a fetch-valid qualifier.
- Feeds instruction-memory address and IF/ID pipeline register; redirect driven by EX-stage branch resolution.

Parameters:
- N, 32, PC width in bits.
- INC, 4, sequential increment in bytes; power of two, ≤ 2^(N-1).
- RESET_PC, 0, PC value loaded on reset; must be INC-aligned.
- RAS_DEPTH, 4, return-address-stack entries; used only with PC_RAS_EN; power of two ≥ 2.

Ports:
- clk  input  1  clock, all state on posedge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC (hazard unit).
- redirect  input  1  load target (taken branch/jump/flush).
- target  input  N  redirect destination.
- halt  input  1  enter HALTED.
- resume  input  1  leave HALTED sequentially.
- pc  output  N  current fetch address.
- pc_valid  output  1  pc is a real fetch this cycle.
- misalign  output  1  one-cycle pulse: accepted target was not INC-aligned.
- halted  output  1  state == HALTED.
- call, ret  input  1 each  PC_RAS_EN only.
- ras_err  output  1  PC_RAS_EN only.

Behaviour:
- Reset is synchronous, active-high, with one clock. Reset overrides every input.
  - On reset: pc=RESET_PC, pc_valid=0, misalign=0, halted=0, ras_err=0, state=BOOT, RAS emptied.
- States:
  - BOOT: one cycle, pc held, pc_valid=0. Next state is RUN unconditionally; inputs ignored.
  - RUN: pc_valid=1.
  - HALTED: pc_valid=0, halted=1.
- RUN priority, evaluated each cycle (highest first):
  - redirect: pc<=target with low log2(INC) bits cleared. misalign=1 next cycle if those bits were nonzero. Redirect overrides stall and halt in the same cycle.
  - halt: pc held; next state HALTED.
  - stall: pc held; pc_valid stays 1 (same address re-presented).
  - otherwise: pc<=pc+INC, modulo 2^N. The all-ones-aligned address wraps to 0 with no flag.
- HALTED:
  - redirect: pc<=aligned target, next state RUN.
  - else resume: pc<=pc+INC, next state RUN.
  - else hold. stall is ignored while halted.
- Latency: every change of pc is visible the cycle after the qualifying input edge. No combinational path from inputs to pc.
- misalign is a registered single-cycle pulse, otherwise 0.
- Reset mid-operation (any state) returns to BOOT at the next edge. Pending halt or redirect is discarded.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined: call, ret and ras_err ports exist, plus a RAS_DEPTH circular return-address stack.
  - call is accepted only with redirect=1 in RUN. It pushes pc+INC and pc<=target.
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - ret in RUN with stack non-empty and redirect=0: pc<=top, pop.
  - ret while empty: sequential increment, ras_err pulses one cycle.
  - call and ret together: call wins, ret ignored.
  - A stall cycle suppresses push and pop.
- Undefined: ports and stack are absent; behaviour is identical to the above with call=ret=0.

Decomposition:
- Package pc_pkg holds:
  - state enum pc_state_t {BOOT, RUN, HALTED};
  - localparam helpers ALIGN_BITS=$clog2(INC) and RAS_PTR_W=$clog2(RAS_DEPTH).
- One sub-module, pc_ras: push/pop/full/empty/top, synchronous reset. Instantiated only under PC_RAS_EN.

Test Plan:
- Reset then free-run (N=32, INC=4, RESET_PC=0x100) -> pc=0x100 with pc_valid=0 for 1 cycle, then 0x100, 0x104, 0x108 with pc_valid=1.
- stall held 3 cycles at pc=0x108, with redirect target=0x2002 during the 2nd stall cycle -> pc=0x2000 next cycle, misalign=1 for exactly 1 cycle.
- halt at pc=0x200 -> pc holds 0x200, halted=1, pc_valid=0 across 5 cycles; resume -> pc=0x204, pc_valid=1.
- Wrap: redirect target=0xFFFFFFFC -> next cycle 0xFFFFFFFC, following cycle 0x00000000.
- Reset asserted while HALTED with redirect=1 -> pc=RESET_PC, BOOT one cycle, redirect discarded.
- PC_RAS_EN, RAS_DEPTH=2: three calls from 0x10, 0x20, 0x30, then ret, ret, ret ->
  - first ret returns 0x34, second returns 0x24;
  - third ret increments and ras_err pulses once.
